// File: rtl/ofm_packer.sv
// ofm_packer: packs 8-bit PE results four per 32-bit word, little-endian
// byte lanes, and writes the words to output memory at consecutive
// addresses. The design holds one assembly word and one pending write.
module ofm_packer #(
  parameter int ADDR_W    = 8,
  parameter int OFM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        macout,
  input  logic              wrofm,
  input  logic              mem_ready,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int CNT_W = ADDR_W + 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OFM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        lane_q, lane_d;
  logic              full_q, full_d;
  logic              pvld_q, pvld_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [31:0]       pdata_q, pdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              in_collect, accept, pend_free, move, cap, complete;
  logic              direct, last_to_pend, drop;
  logic [31:0]       base_word, new_word;
  logic [1:0]        base_lane;
  logic [CNT_W-1:0]  cnt_inc;

  // Decode the per-cycle events: pending accept, assembly move, byte capture.
  always_comb begin
    in_collect   = (state_q == S_COLLECT);
    accept       = pvld_q & mem_ready;
    pend_free    = ~pvld_q | accept;
    // A full assembly word leaves for pending as soon as pending frees up.
    move         = in_collect & full_q & pend_free;
    cap          = in_collect & wrofm & (cnt_q < LAST_CNT) & (~full_q | move);
    drop         = in_collect & wrofm & full_q & ~move;
    // When the full word moves out this cycle, the new byte starts a fresh word.
    base_word    = move ? 32'd0 : asm_q;
    base_lane    = move ? 2'd0 : lane_q;
    new_word     = base_word | ({24'd0, macout} << {base_lane, 3'b000});
    cnt_inc      = cnt_q + CNT_W'(1);
    complete     = cap & ((base_lane == 2'd3) | (cnt_inc == LAST_CNT));
    // A completed word bypasses assembly when pending is free and not taken by a move.
    direct       = complete & pend_free & ~move;
    last_to_pend = (move & (cnt_q == LAST_CNT)) | (direct & (cnt_inc == LAST_CNT));
  end

  // Next-state logic for the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start)        state_d = S_COLLECT;
      S_COLLECT: if (last_to_pend) state_d = S_FLUSH;
      S_FLUSH:   if (accept)       state_d = S_DONE;
      S_DONE:                      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Next values for counters, assembly word, pending write and status flags.
  always_comb begin
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    base_d  = base_q;
    asm_d   = asm_q;
    lane_d  = lane_q;
    full_d  = full_q;
    pvld_d  = pvld_q;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    ovf_d   = ovf_q;

    if ((state_q == S_IDLE) && start) begin
      cnt_d  = '0;
      widx_d = '0;
      base_d = base_addr;
      asm_d  = '0;
      lane_d = '0;
      full_d = 1'b0;
      ovf_d  = 1'b0;
    end

    if (move) begin
      pvld_d  = 1'b1;
      pdata_d = asm_q;
      paddr_d = base_q + widx_q;
      widx_d  = widx_q + ADDR_W'(1);
    end else if (direct) begin
      pvld_d  = 1'b1;
      pdata_d = new_word;
      paddr_d = base_q + widx_q;
      widx_d  = widx_q + ADDR_W'(1);
    end else if (accept) begin
      pvld_d  = 1'b0;
    end

    if (cap) begin
      cnt_d = cnt_inc;
      if (direct) begin
        asm_d  = '0;
        lane_d = '0;
        full_d = 1'b0;
      end else if (complete) begin
        asm_d  = new_word;
        lane_d = '0;
        full_d = 1'b1;
      end else begin
        asm_d  = new_word;
        lane_d = base_lane + 2'd1;
        full_d = 1'b0;
      end
    end else if (move) begin
      asm_d  = '0;
      lane_d = '0;
      full_d = 1'b0;
    end

    if (drop) ovf_d = 1'b1;

    busy_d = (state_d == S_COLLECT) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      base_q  <= '0;
      asm_q   <= '0;
      lane_q  <= '0;
      full_q  <= 1'b0;
      pvld_q  <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      base_q  <= base_d;
      asm_q   <= asm_d;
      lane_q  <= lane_d;
      full_q  <= full_d;
      pvld_q  <= pvld_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_wEn  = pvld_q;
  assign mem_addr = paddr_q;
  assign mem_data = pdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ofm_packer.sv
// Directed testbench for ofm_packer: three instances cover the 8-byte map,
// the 6-byte partial-word map and the 4-bit address wrap case.
module tb_ofm_packer;

  logic        clk;
  logic        rst;
  logic        mem_ready;
  logic        wrofm;
  logic [7:0]  macout;

  logic        start8, start6, start4;
  logic [7:0]  base8, base6;
  logic [3:0]  base4;

  logic        wen8, wen6, wen4;
  logic [7:0]  addr8, addr6;
  logic [3:0]  addr4;
  logic [31:0] data8, data6, data4;
  logic        busy8, busy6, busy4;
  logic        done8, done6, done4;
  logic        ovf8, ovf6, ovf4;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          qbase = 0;
  int          dbase = 0;
  logic [31:0] qa[$];
  logic [31:0] qd[$];

  ofm_packer #(.ADDR_W(8), .OFM_BYTES(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .base_addr(base8), .macout(macout),
    .wrofm(wrofm), .mem_ready(mem_ready), .mem_wEn(wen8), .mem_addr(addr8),
    .mem_data(data8), .busy(busy8), .done(done8), .overflow(ovf8)
  );

  ofm_packer #(.ADDR_W(8), .OFM_BYTES(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .base_addr(base6), .macout(macout),
    .wrofm(wrofm), .mem_ready(mem_ready), .mem_wEn(wen6), .mem_addr(addr6),
    .mem_data(data6), .busy(busy6), .done(done6), .overflow(ovf6)
  );

  ofm_packer #(.ADDR_W(4), .OFM_BYTES(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .base_addr(base4), .macout(macout),
    .wrofm(wrofm), .mem_ready(mem_ready), .mem_wEn(wen4), .mem_addr(addr4),
    .mem_data(data4), .busy(busy4), .done(done4), .overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted write and every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_ready) begin
      if (wen8) begin qa.push_back({24'd0, addr8}); qd.push_back(data8); end
      if (wen6) begin qa.push_back({24'd0, addr6}); qd.push_back(data6); end
      if (wen4) begin qa.push_back({28'd0, addr4}); qd.push_back(data4); end
    end
    if (done8 || done6 || done4) n_done++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    wrofm  = 1'b1;
    macout = b;
    tick();
  endtask

  task automatic begin_test();
    qbase = qa.size();
    dbase = n_done;
  endtask

  function automatic logic [31:0] wr_addr(input int i);
    if (qbase + i < qa.size()) return qa[qbase + i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wr_data(input int i);
    if (qbase + i < qd.size()) return qd[qbase + i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic check_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    check({tag, " addr"}, wr_addr(i), a);
    check({tag, " data"}, wr_data(i), d);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(done8 || done6 || done4) && n < 40) begin
      tick();
      n++;
    end
    check({tag, " done"}, done8 | done6 | done4, 1);
    check({tag, " busy low at done"}, busy8 | busy6 | busy4, 0);
    tick();
    check({tag, " done one cycle"}, done8 | done6 | done4, 0);
    check({tag, " done count"}, n_done - dbase, 1);
  endtask

  initial begin
    rst = 1'b0; mem_ready = 1'b0; wrofm = 1'b0; macout = 8'd0;
    start8 = 1'b0; start6 = 1'b0; start4 = 1'b0;
    base8 = 8'd0; base6 = 8'd0; base4 = 4'd0;
    tick(); tick();
    check("reset wEn", wen8, 0);
    check("reset addr", addr8, 0);
    check("reset data", data8, 0);
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset overflow", ovf8, 0);
    rst = 1'b1;
    tick();

    // Basic packing with an ignored start mid-map.
    begin_test();
    mem_ready = 1'b1; base8 = 8'h10; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t1 busy after start", busy8, 1);
    for (int i = 1; i <= 8; i++) begin
      start8 = (i == 2);
      if (i == 2) base8 = 8'h40;
      send(8'(i));
      if (i == 4) begin
        check("t1 word latency wEn", wen8, 1);
        check("t1 word latency addr", addr8, 8'h10);
        check("t1 word latency data", data8, 32'h04030201);
      end
    end
    wrofm = 1'b0; start8 = 1'b0;
    wait_done("t1");
    check("t1 writes", qa.size() - qbase, 2);
    check_wr("t1 w0", 0, 32'h10, 32'h04030201);
    check_wr("t1 w1", 1, 32'h11, 32'h08070605);
    check("t1 overflow", ovf8, 0);

    // Partial last word.
    begin_test();
    base6 = 8'h20; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(8'hA1 + i));
    wrofm = 1'b0;
    wait_done("t2");
    check("t2 writes", qa.size() - qbase, 2);
    check_wr("t2 w0", 0, 32'h20, 32'hA4A3A2A1);
    check_wr("t2 w1", 1, 32'h21, 32'h0000A6A5);

    // Backpressure: pending stalls for 5 cycles while bytes 5..8 arrive.
    begin_test();
    mem_ready = 1'b0; base8 = 8'h30; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      check("t3 stall wEn", wen8, 1);
      check("t3 stall addr", addr8, 8'h30);
      check("t3 stall data", data8, 32'h14131211);
      if (k < 4) begin
        wrofm = 1'b1; macout = 8'(8'h15 + k);
      end else begin
        wrofm = 1'b0;
      end
      tick();
    end
    check("t3 overflow", ovf8, 0);
    mem_ready = 1'b1;
    wait_done("t3");
    check("t3 writes", qa.size() - qbase, 2);
    check_wr("t3 w0", 0, 32'h30, 32'h14131211);
    check_wr("t3 w1", 1, 32'h31, 32'h18171615);

    // Overflow: ninth byte dropped while both registers are full.
    begin_test();
    mem_ready = 1'b0; base8 = 8'h50; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send(8'(8'h20 + i));
      if (i == 8) check("t4 no overflow yet", ovf8, 0);
    end
    wrofm = 1'b0;
    check("t4 overflow set", ovf8, 1);
    mem_ready = 1'b1;
    wait_done("t4");
    check("t4 writes", qa.size() - qbase, 2);
    check_wr("t4 w0", 0, 32'h50, 32'h24232221);
    check_wr("t4 w1", 1, 32'h51, 32'h28272625);
    check("t4 overflow sticky", ovf8, 1);

    // Reset mid-map discards the pending word.
    begin_test();
    mem_ready = 1'b0; base8 = 8'h60; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t5 start clears overflow", ovf8, 0);
    for (int i = 1; i <= 4; i++) send(8'(8'h30 + i));
    wrofm = 1'b0;
    check("t5 pending before reset", wen8, 1);
    rst = 1'b0;
    #1;
    check("t5 async wEn", wen8, 0);
    check("t5 async addr", addr8, 0);
    check("t5 async data", data8, 0);
    check("t5 async busy", busy8, 0);
    tick();
    rst = 1'b1; mem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(8'h40 + i));
    wrofm = 1'b0;
    tick(); tick();
    check("t5 no writes after reset", qa.size() - qbase, 0);
    check("t5 idle wEn", wen8, 0);
    check("t5 idle busy", busy8, 0);

    // Address wrap with a 4-bit address.
    begin_test();
    base4 = 4'hF; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    wrofm = 1'b0;
    wait_done("t6");
    check("t6 writes", qa.size() - qbase, 2);
    check_wr("t6 w0", 0, 32'hF, 32'h04030201);
    check_wr("t6 w1", 1, 32'h0, 32'h08070605);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ofm_packer.md
# ofm_packer

Output-feature-map write-back block for the CNN datapath. It collects the 8-bit `macout` results a PE emits on each `wrofm` strobe and packs four results per 32-bit word. It then writes the words sequentially into output memory. It is the write-side counterpart of the 32-bit memory words that PEs read as kernel/picture input, and uses the same little-endian byte-lane layout (byte 0 in bits [7:0]).

## Interface
- `ADDR_W`, 8, output-memory word-address width
- `OFM_BYTES`, 64, number of results in one output map (1 .. 4·2^ADDR_W)
- `clk`  input  1  system clock, rising-edge
- `rst`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle pulse; begins a new output map (accepted only in IDLE)
- `base_addr`  input  ADDR_W  first word address; latched on accepted `start`
- `macout`  input  8  PE result byte
- `wrofm`  input  1  strobe: `macout` is valid this cycle
- `mem_ready`  input  1  memory accepts the write this cycle
- `mem_wEn`  output  1  write request; held until `mem_ready`
- `mem_addr`  output  ADDR_W  word address of the pending write
- `mem_data`  output  32  packed word
- `busy`  output  1  high in COLLECT and FLUSH
- `done`  output  1  one-cycle pulse after the last word is accepted
- `overflow`  output  1  sticky: a byte was dropped; cleared by the next accepted `start`

## Operation
- States:
  - IDLE: accepted `start` → COLLECT; clears the byte counter, word index, assembly register and `overflow`.
  - COLLECT: when the last byte reaches the pending register → FLUSH.
  - FLUSH: `mem_wEn`·`mem_ready` on the last word → DONE.
  - DONE: always → IDLE next cycle; `done` = 1 for that one cycle.
- Storage is two registers:
  - Assembly register: 32-bit word plus a 2-bit lane index.
  - Pending register: holds `mem_data`/`mem_addr`; its valid flag drives `mem_wEn`.
- Byte capture:
  - In COLLECT, `wrofm` writes `macout` into lane `lane_idx` (lane 0 = bits [7:0]).
  - Lanes not yet written read as 0.
- Word completion: the word is complete on lane 3, or on byte number `OFM_BYTES`. A partial last word keeps its unwritten upper lanes at 0.
- Completed word moves to pending when pending is empty, or is being accepted (`mem_wEn`·`mem_ready`) in the same cycle.
  - `mem_addr` = `base_addr` + word index; the index is modulo 2^ADDR_W and wraps silently.
  - Otherwise the word stays in assembly (assembly full).
- Overflow: `wrofm` while assembly is full (and not moving this cycle) → byte dropped, `overflow` ← 1. The byte counter does not advance.
- Ignored inputs:
  - `wrofm` outside COLLECT.
  - `start` outside IDLE.
  - `mem_ready` while `mem_wEn` = 0.
- `mem_wEn`, `mem_addr` and `mem_data` stay stable while `mem_wEn` = 1 and `mem_ready` = 0.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State IDLE.
  - All outputs 0: `mem_wEn`, `mem_addr`, `mem_data`, `busy`, `done`, `overflow`.
  - All counters and registers cleared.
  - Reset mid-map discards any pending word; no further writes occur.
- All outputs are registered.
- `busy` rises the cycle after an accepted `start`.
- Word latency: the edge that captures a completing byte (pending free) → `mem_wEn` = 1 in the following cycle.
- With `mem_ready` held at 1:
  - One write per completed word; each write is accepted in its first `mem_wEn` cycle.
  - Sustained input of one byte per cycle is lossless.
- `done` is high the cycle after the last write is accepted. `busy` falls in that same cycle.
- Simultaneous events:
  - Pending accepted and a completing byte on the same edge → the new word enters pending with no bubble cycle.
  - `wrofm` and a lane-3 completion on the same edge as a blocked pending → that byte completes assembly normally. Only a later `wrofm` while still blocked overflows.

## Test plan
- Basic packing (OFM_BYTES=8, base_addr=0x10, `mem_ready`=1): bytes 0x01..0x08 on consecutive cycles.
  - Required: writes 0x04030201@0x10 and 0x08070605@0x11.
  - Then `done` pulses once; `overflow`=0.
- Partial last word (OFM_BYTES=6): bytes 0xA1..0xA6.
  - Required: 0xA4A3A2A1@base, then 0x0000A6A5@base+1.
- Backpressure: hold `mem_ready`=0 for 5 cycles after the first `mem_wEn`.
  - Required: address and data stable throughout.
  - Bytes 5–8 arriving during the stall still complete the second word with no loss.
- Overflow: `mem_ready`=0; send 9 bytes.
  - Required: `overflow`=1 after the 9th byte.
  - After release: words 1 and 2 are written intact, and the dropped byte is absent.
- Reset and ignored `start`:
  - `start` while busy → no effect on the address sequence.
  - `rst` low mid-map → all outputs 0 immediately; no write after release until a new `start`.
- Address wrap (ADDR_W=4, base_addr=0xF, OFM_BYTES=8): second write goes to address 0x0.
